// File: rtl/frame_grabber.sv
// VGA capture stage: after an arm, grabs one decimated frame as packed 8-bit luma into a FIFO drained over Avalon-MM.
// Define FRAME_GRABBER_IRQ_EN to drive irq from frame_done & irq_en; otherwise irq is tied low.
module frame_grabber #(
    parameter int H_BACK     = 48,
    parameter int H_ACTIVE   = 640,
    parameter int V_BACK     = 33,
    parameter int V_ACTIVE   = 480,
    parameter int DECIM_LOG2 = 2,
    parameter int FIFO_DEPTH = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [7:0]  VGA_R,
    input  logic [7:0]  VGA_G,
    input  logic [7:0]  VGA_B,
    input  logic        HSYNC,
    input  logic        VSYNC,
    input  logic        pix_en,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int H_END = H_BACK + H_ACTIVE;
    localparam int V_END = V_BACK + V_ACTIVE;
    localparam logic [15:0] DMASK = 16'((1 << DECIM_LOG2) - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_VS = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           hs_prev_q, vs_prev_q;
    logic [15:0]    hcnt_q, vcnt_q;
    logic [1:0]     idx_q;
    logic [31:0]    pack_q, word_q;
    logic           push_q;
    logic [31:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           overflow_q, frame_done_q;
    logic [31:0]    readdata_q;

    logic        wr0, arm, rd_any, pop, full, push_ok, drop;
    logic        hs_rise, vs_rise, frame_end;
    logic        busy, start_cap, in_cap, set_done, keep;
    logic [15:0] hoff, voff;
    logic [9:0]  sum;
    logic [7:0]  luma;

    assign wr0    = chipselect & write & (address == 8'd0);
    assign arm    = wr0 & writedata[0];
    assign rd_any = chipselect & read;

    // Sync edges only count on strobe cycles, so the previous value is sampled on pix_en too.
    assign hs_rise   = pix_en & HSYNC & ~hs_prev_q;
    assign vs_rise   = pix_en & VSYNC & ~vs_prev_q;
    assign frame_end = hs_rise & ((vcnt_q + 16'd1) == 16'(V_END));

    assign hoff = hcnt_q - 16'(H_BACK);
    assign voff = vcnt_q - 16'(V_BACK);
    assign sum  = {2'b00, VGA_R} + {1'b0, VGA_G, 1'b0} + {2'b00, VGA_B};
    assign luma = sum[9:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = S_WAIT_VS;
        end else begin
            case (state_q)
                S_WAIT_VS: if (vs_rise) state_d = S_CAPTURE;
                S_CAPTURE: if (vs_rise || frame_end) state_d = S_DONE;
                default:   state_d = state_q;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q == S_WAIT_VS) || (state_q == S_CAPTURE);
        start_cap = (state_q == S_WAIT_VS) && vs_rise && !arm;
        in_cap    = (state_q == S_CAPTURE) && !arm;
        set_done  = in_cap && (vs_rise || frame_end);
        keep      = in_cap && pix_en && !hs_rise && !vs_rise
                    && (hcnt_q >= 16'(H_BACK)) && (hcnt_q < 16'(H_END))
                    && (vcnt_q >= 16'(V_BACK)) && (vcnt_q < 16'(V_END))
                    && ((hoff & DMASK) == 16'd0) && ((voff & DMASK) == 16'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
        end else begin
            if (pix_en) begin
                hs_prev_q <= HSYNC;
                vs_prev_q <= VSYNC;
            end
            if (start_cap) begin
                hcnt_q <= '0;
                vcnt_q <= '0;
            end else if (in_cap && pix_en) begin
                if (hs_rise) begin
                    hcnt_q <= '0;
                    vcnt_q <= vcnt_q + 16'd1;
                end else begin
                    hcnt_q <= hcnt_q + 16'd1;
                end
            end
        end
    end

    // The completed word is staged in word_q and pushed one cycle after its fourth byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q  <= '0;
            pack_q <= '0;
            word_q <= '0;
            push_q <= 1'b0;
        end else if (arm) begin
            idx_q  <= '0;
            pack_q <= '0;
            push_q <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (keep) begin
                pack_q[idx_q*8 +: 8] <= luma;
                idx_q                <= idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    word_q <= {luma, pack_q[23:0]};
                    push_q <= 1'b1;
                end
            end
        end
    end

    assign pop     = rd_any && (address == 8'd0) && (count_q != '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign push_ok = push_q && (!full || pop);
    assign drop    = push_q && !push_ok;

    always_ff @(posedge clk) begin
        if (push_ok && !arm) mem_q[wr_ptr_q] <= word_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
            readdata_q   <= '0;
        end else if (arm) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push_ok) count_q <= count_q - 1'b1;
            if (drop)     overflow_q   <= 1'b1;
            if (set_done) frame_done_q <= 1'b1;
            if (rd_any) begin
                if (address == 8'd0)
                    readdata_q <= pop ? mem_q[rd_ptr_q] : 32'd0;
                else if (address == 8'd1)
                    readdata_q <= {16'(count_q), 13'd0, overflow_q, frame_done_q, busy};
                else
                    readdata_q <= 32'd0;
            end
        end
    end

    assign readdata = readdata_q;

`ifdef FRAME_GRABBER_IRQ_EN
    logic irq_en_q, irq_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr0) irq_en_q <= writedata[1];
            irq_q <= frame_done_q & irq_en_q;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = &{1'b0, writedata[31:1], sum[1:0]};

endmodule

// File: tb/tb_frame_grabber.sv
// Self-checking bench for frame_grabber: synthetic VGA frames with random colours and junk blanking,
// expected FIFO words built from the pixel arrays, plus a 2-deep instance to exercise overflow.
module tb_frame_grabber;
    localparam int H_BACK      = 2;
    localparam int H_ACTIVE    = 8;
    localparam int V_BACK      = 1;
    localparam int V_ACTIVE    = 2;
    localparam int DECIM_LOG2  = 0;
    localparam int FIFO_DEPTH  = 4;
    localparam int SMALL_DEPTH = 2;
    localparam int DSTEP       = 1 << DECIM_LOG2;
    localparam int WPF         = ((V_ACTIVE / DSTEP) * (H_ACTIVE / DSTEP)) / 4;
`ifdef FRAME_GRABBER_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, chipselect, read, write;
    logic [7:0]  address;
    logic [31:0] writedata, readdata, readdata_s;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync, pix_en;
    logic        irq, irq_s;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  fr_r [V_ACTIVE][H_ACTIVE];
    logic [7:0]  fr_g [V_ACTIVE][H_ACTIVE];
    logic [7:0]  fr_b [V_ACTIVE][H_ACTIVE];

    frame_grabber #(
        .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE),
        .DECIM_LOG2(DECIM_LOG2), .FIFO_DEPTH(FIFO_DEPTH)
    ) u_dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata),
        .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
        .HSYNC(hsync), .VSYNC(vsync), .pix_en(pix_en), .irq(irq)
    );

    frame_grabber #(
        .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE), .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE),
        .DECIM_LOG2(DECIM_LOG2), .FIFO_DEPTH(SMALL_DEPTH)
    ) u_small (
        .clk(clk), .reset(reset), .chipselect(chipselect), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata_s),
        .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
        .HSYNC(hsync), .VSYNC(vsync), .pix_en(pix_en), .irq(irq_s)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] stat(input int cnt, input logic ovf, input logic done,
                                         input logic bsy);
        return {16'(cnt), 13'd0, ovf, done, bsy};
    endfunction

    function automatic logic [7:0] luma(input int r, input int g, input int b);
        return 8'((r + 2 * g + b) / 4);
    endfunction

    // Driver tasks: all inputs change on the falling edge
    task automatic strobe(input logic hs, input logic vs, input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b);
        @(negedge clk);
        hsync = hs; vsync = vs; vga_r = r; vga_g = g; vga_b = b;
    endtask

    task automatic junk(input logic hs, input logic vs);
        strobe(hs, vs, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)));
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; writedata = '0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output logic [31:0] ds);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        d = readdata; ds = readdata_s;
        chipselect = 1'b0; read = 1'b0;
    endtask

    // VSYNC pulse, then nl lines; column k of a line is the k-th strobe after its HSYNC rise.
    task automatic drive_frame(input int nl);
        repeat (2) junk(1'b1, 1'b0);
        junk(1'b1, 1'b1);
        for (int l = 0; l < nl; l++) begin
            for (int k = 0; k < H_BACK + H_ACTIVE + 2; k++) begin
                int ln, cl;
                ln = l - V_BACK;
                cl = k - H_BACK;
                if (ln >= 0 && ln < V_ACTIVE && cl >= 0 && cl < H_ACTIVE)
                    strobe(1'b1, 1'b1, fr_r[ln][cl], fr_g[ln][cl], fr_b[ln][cl]);
                else
                    junk(1'b1, 1'b1);
            end
            junk(1'b0, 1'b1);
            junk(1'b0, 1'b1);
            junk(1'b1, 1'b1);
        end
        repeat (4) junk(1'b1, 1'b1);
    endtask

    task automatic set_pattern();
        for (int l = 0; l < V_ACTIVE; l++)
            for (int c = 0; c < H_ACTIVE; c++) begin
                fr_r[l][c] = 8'(c); fr_g[l][c] = 8'(c); fr_b[l][c] = 8'(c);
            end
    endtask

    task automatic set_random(input logic corners);
        for (int l = 0; l < V_ACTIVE; l++)
            for (int c = 0; c < H_ACTIVE; c++) begin
                fr_r[l][c] = 8'($urandom_range(0, 255));
                fr_g[l][c] = 8'($urandom_range(0, 255));
                fr_b[l][c] = 8'($urandom_range(0, 255));
            end
        if (corners) begin
            fr_r[0][0] = 8'hFF; fr_g[0][0] = 8'hFF; fr_b[0][0] = 8'hFF;
            fr_r[0][1] = 8'hFF; fr_g[0][1] = 8'h00; fr_b[0][1] = 8'h00;
        end
    endtask

    // Reference: kept pixels in raster order, four luma bytes per word, first byte lowest.
    task automatic model_frame();
        int n;
        logic [31:0] w;
        exp_q.delete();
        n = 0;
        w = '0;
        for (int l = 0; l < V_ACTIVE; l += DSTEP)
            for (int c = 0; c < H_ACTIVE; c += DSTEP) begin
                w[8*n +: 8] = luma(fr_r[l][c], fr_g[l][c], fr_b[l][c]);
                n++;
                if (n == 4) begin
                    exp_q.push_back(w);
                    n = 0;
                    w = '0;
                end
            end
    endtask

    task automatic drain_check(input string tag, output logic [31:0] first);
        logic [31:0] d, ds, e;
        first = '0;
        for (int i = 0; i < WPF; i++) begin
            e = exp_q.pop_front();
            bus_read(8'd0, d, ds);
            if (i == 0) first = d;
            check({tag, "_word"}, d, e);
            check({tag, "_small_word"}, ds, (i < SMALL_DEPTH) ? e : 32'h0);
        end
    endtask

    task automatic status_check(input string tag, input logic [31:0] exp_main,
                                input logic [31:0] exp_small);
        logic [31:0] d, ds;
        bus_read(8'd1, d, ds);
        check({tag, "_status"}, d, exp_main);
        check({tag, "_small_status"}, ds, exp_small);
    endtask

    initial begin
        logic [31:0] d, ds, first;
        reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; writedata = '0; vga_r = '0; vga_g = '0; vga_b = '0;
        hsync = 1'b1; vsync = 1'b1; pix_en = 1'b1;

        // Reset held while every input toggles randomly
        repeat (6) begin
            @(negedge clk);
            chipselect = 1'($urandom_range(0, 1));
            read       = 1'($urandom_range(0, 1));
            write      = 1'($urandom_range(0, 1));
            address    = 8'($urandom_range(0, 2));
            writedata  = $urandom;
            vga_r      = 8'($urandom_range(0, 255));
            hsync      = 1'($urandom_range(0, 1));
            vsync      = 1'($urandom_range(0, 1));
            #1;
            check("reset_readdata", readdata, 32'h0);
            check("reset_irq", irq, 1'b0);
        end
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0; write = 1'b0; writedata = '0;
        hsync = 1'b1; vsync = 1'b1;
        reset = 1'b0;
        status_check("post_reset", 32'h0, 32'h0);

        // Index pattern frame with irq enabled
        set_pattern();
        bus_write(8'd0, 32'h3);
        status_check("armed", stat(0, 0, 0, 1), stat(0, 0, 0, 1));
        drive_frame(V_BACK + V_ACTIVE);
        model_frame();
        check("pattern_exp0", exp_q[0], 32'h03020100);
        status_check("pattern_done", stat(FIFO_DEPTH, 0, 1, 0), stat(SMALL_DEPTH, 1, 1, 0));
        check("irq_done", irq, IRQ_ON);
        drain_check("pattern", first);
        check("pattern_first", first, 32'h03020100);
        status_check("drained", stat(0, 0, 1, 0), stat(0, 1, 1, 0));
        bus_read(8'd0, d, ds);
        check("empty_read", d, 32'h0);
        check("empty_read_small", ds, 32'h0);
        status_check("empty_count", stat(0, 0, 1, 0), stat(0, 1, 1, 0));
        bus_write(8'd0, 32'h0);
        @(negedge clk);
        check("irq_en_cleared", irq, 1'b0);

        // Re-arm clears overflow and done on both instances
        bus_write(8'd0, 32'h1);
        status_check("rearm", stat(0, 0, 0, 1), stat(0, 0, 0, 1));
        check("rearm_irq", irq, 1'b0);

        // Random frames, the first carrying white and pure-red pixels
        for (int f = 0; f < 3; f++) begin
            set_random(f == 0);
            if (f != 0) bus_write(8'd0, 32'h1);
            drive_frame(V_BACK + V_ACTIVE);
            model_frame();
            status_check("rand_done", stat(FIFO_DEPTH, 0, 1, 0), stat(SMALL_DEPTH, 1, 1, 0));
            drain_check("rand", first);
            if (f == 0) begin
                check("white_byte", first[7:0], 8'hFF);
                check("red_byte", first[15:8], 8'h3F);
            end
        end

        // Arm mid-frame restarts, then reset lands during capture
        set_random(1'b0);
        bus_write(8'd0, 32'h1);
        drive_frame(2);
        status_check("mid_frame", stat(2, 0, 0, 1), stat(2, 0, 0, 1));
        bus_write(8'd0, 32'h1);
        status_check("mid_rearm", stat(0, 0, 0, 1), stat(0, 0, 0, 1));
        drive_frame(2);
        status_check("mid_capture", stat(2, 0, 0, 1), stat(2, 0, 0, 1));
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_state", 32'(u_dut.state_q), 32'h0);
        check("async_count", 32'(u_dut.count_q), 32'h0);
        check("async_readdata", readdata, 32'h0);
        check("async_irq", irq, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        status_check("after_reset", 32'h0, 32'h0);

        // Empty pop, unmapped read and ignored write
        bus_read(8'd0, d, ds);
        check("idle_empty_read", d, 32'h0);
        status_check("idle_count", 32'h0, 32'h0);
        bus_read(8'd5, d, ds);
        check("unmapped_read", d, 32'h0);
        bus_write(8'd3, 32'h3);
        status_check("ignored_write", 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
